// File: rtl/rr_arbiter_8.sv
// Eight-way round-robin arbiter with a bounded hold time per grant.
// Grants are presented as a registered binary index plus valid for a 3-to-8 decoder.
module rr_arbiter_8 #(
  parameter int unsigned MAX_HOLD = 15
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] req,
  input  logic       done,
  output logic [2:0] gnt_idx,
  output logic       gnt_vld,
  output logic       timeout
);

  typedef enum logic {IDLE, GRANT} state_t;

  state_t     state;
  logic [2:0] ptr;
  logic [3:0] hold_cnt;

  logic       found;
  logic [2:0] pick;
  logic       hold_limit;
  logic       req_drop;

  // Rotating priority search: first requester at or above ptr, modulo 8.
  always_comb begin
    // NOTE: every variable gets a default before any branch so no latch is inferred.
    found = 1'b0;
    pick  = ptr;
    for (int i = 0; i < 8; i++) begin
      automatic logic [2:0] idx = ptr + 3'(i);
      if (!found && req[idx]) begin
        found = 1'b1;
        pick  = idx;
      end
    end
  end

  assign hold_limit = (hold_cnt == 4'(MAX_HOLD - 1));
  assign req_drop   = !req[gnt_idx];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      ptr      <= '0;
      hold_cnt <= '0;
      gnt_idx  <= '0;
      gnt_vld  <= 1'b0;
      timeout  <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every register sees pre-edge values.
      case (state)
        IDLE: begin
          timeout <= 1'b0;
          gnt_vld <= 1'b0;
          if (found) begin
            state    <= GRANT;
            gnt_idx  <= pick;
            gnt_vld  <= 1'b1;
            ptr      <= pick + 3'd1;
            hold_cnt <= '0;
          end
        end
        GRANT: begin
          if (done || req_drop || hold_limit) begin
            state   <= IDLE;
            gnt_vld <= 1'b0;
            // Timeout only flags a forced revoke, never a voluntary or coincident release.
            timeout <= hold_limit && !done && !req_drop;
          end else if (hold_cnt != 4'hF) begin
            hold_cnt <= hold_cnt + 4'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_rr_arbiter_8.sv
// Directed testbench for rr_arbiter_8: hand-computed grant sequences, hold limit,
// request drop, asynchronous reset mid-grant and done/limit coincidence.
module tb_rr_arbiter_8;

  logic       clk;
  logic       rst_n;
  logic [7:0] req;
  logic       done;
  logic [2:0] gnt_idx;
  logic       gnt_vld;
  logic       timeout;

  int checks = 0;
  int errors = 0;

  rr_arbiter_8 #(.MAX_HOLD(15)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .req     (req),
    .done    (done),
    .gnt_idx (gnt_idx),
    .gnt_vld (gnt_vld),
    .timeout (timeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [7:0] observed, input logic [7:0] expected);
    checks++;
    assert (observed === expected)
      else begin
        errors++;
        $error("FAIL %s observed %0h expected %0h", tag, observed, expected);
      end
  endtask

  // Advance one rising edge and settle just after it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_reset();
    rst_n = 1'b0;
    #3;
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n = 1'b0;
    req   = 8'h00;
    done  = 1'b0;
    #2;
    check("reset_vld", {7'b0, gnt_vld}, 8'h00);
    check("reset_idx", {5'b0, gnt_idx}, 8'h00);
    check("reset_timeout", {7'b0, timeout}, 8'h00);
    #10;
    rst_n = 1'b1;
    tick();
    check("idle_after_reset", {7'b0, gnt_vld}, 8'h00);

    // Two requesters: 0 first, then 2 after one idle cycle.
    req = 8'b0000_0101;
    tick();
    check("g0_vld", {7'b0, gnt_vld}, 8'h01);
    check("g0_idx", {5'b0, gnt_idx}, 8'h00);
    done = 1'b1;
    tick();
    check("g0_rel_vld", {7'b0, gnt_vld}, 8'h00);
    check("g0_rel_timeout", {7'b0, timeout}, 8'h00);
    done = 1'b0;
    tick();
    check("g2_vld", {7'b0, gnt_vld}, 8'h01);
    check("g2_idx", {5'b0, gnt_idx}, 8'h02);
    done = 1'b1;
    tick();
    done = 1'b0;
    req  = 8'h00;
    tick();
    check("idle_hold_vld", {7'b0, gnt_vld}, 8'h00);
    check("idle_hold_idx", {5'b0, gnt_idx}, 8'h02);
    done = 1'b1;
    tick();
    check("idle_ignores_done", {7'b0, gnt_vld}, 8'h00);
    done = 1'b0;

    // All requesting, done on every grant: 0..7 then wrap to 0.
    pulse_reset();
    req = 8'hFF;
    for (int k = 0; k < 9; k++) begin
      tick();
      check($sformatf("rr_vld_%0d", k), {7'b0, gnt_vld}, 8'h01);
      check($sformatf("rr_idx_%0d", k), {5'b0, gnt_idx}, 8'(k % 8));
      done = 1'b1;
      tick();
      check($sformatf("rr_gap_%0d", k), {7'b0, gnt_vld}, 8'h00);
      done = 1'b0;
    end
    req = 8'h00;
    tick();

    // Hold limit: requester 7 alone, done never asserted.
    req = 8'h80;
    tick();
    check("to_grant_idx", {5'b0, gnt_idx}, 8'h07);
    for (int k = 1; k < 15; k++) begin
      tick();
      check($sformatf("to_hold_%0d", k), {7'b0, gnt_vld}, 8'h01);
    end
    tick();
    check("to_rel_vld", {7'b0, gnt_vld}, 8'h00);
    check("to_pulse", {7'b0, timeout}, 8'h01);
    tick();
    check("to_regrant_vld", {7'b0, gnt_vld}, 8'h01);
    check("to_regrant_idx", {5'b0, gnt_idx}, 8'h07);
    check("to_pulse_once", {7'b0, timeout}, 8'h00);

    // Done arriving on the same edge as the hold limit.
    for (int k = 1; k < 15; k++) tick();
    check("coinc_still_held", {7'b0, gnt_vld}, 8'h01);
    done = 1'b1;
    tick();
    check("coinc_rel_vld", {7'b0, gnt_vld}, 8'h00);
    check("coinc_timeout", {7'b0, timeout}, 8'h00);
    done = 1'b0;
    req  = 8'h00;
    tick();

    // Requester 3 drops mid-grant; other req bits changing have no effect.
    req = 8'h08;
    tick();
    check("drop_grant_idx", {5'b0, gnt_idx}, 8'h03);
    req = 8'h0F;
    tick();
    check("drop_stable_vld", {7'b0, gnt_vld}, 8'h01);
    check("drop_stable_idx", {5'b0, gnt_idx}, 8'h03);
    req = 8'h07;
    tick();
    check("drop_rel_vld", {7'b0, gnt_vld}, 8'h00);
    check("drop_timeout", {7'b0, timeout}, 8'h00);
    tick();
    check("drop_next_idx", {5'b0, gnt_idx}, 8'h00);
    done = 1'b1;
    tick();
    done = 1'b0;
    req  = 8'h00;
    tick();

    // Asynchronous reset in the middle of a grant.
    req = 8'h20;
    tick();
    check("rst_pre_idx", {5'b0, gnt_idx}, 8'h05);
    #2;
    rst_n = 1'b0;
    req   = 8'h10;
    #1;
    check("rst_async_vld", {7'b0, gnt_vld}, 8'h00);
    check("rst_async_idx", {5'b0, gnt_idx}, 8'h00);
    #2;
    rst_n = 1'b1;
    tick();
    check("rst_post_vld", {7'b0, gnt_vld}, 8'h01);
    check("rst_post_idx", {5'b0, gnt_idx}, 8'h04);

    // After another reset the search restarts at requester 0.
    pulse_reset();
    req = 8'h11;
    tick();
    check("ptr_reset_idx", {5'b0, gnt_idx}, 8'h00);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
